// File: rtl/paddle_emu_pkg.sv
// Shared types and helpers for the RC-timer paddle emulator.
// The optional PADDLE_ACCEL_EN build uses ACCEL_THRESH for hold-to-accelerate.
package paddle_emu_pkg;

  typedef enum logic [1:0] {SRC_DIGITAL, SRC_Y, SRC_X, SRC_PADDLE} src_e;

  localparam int unsigned ACCEL_THRESH = 8;

  // Signed two's complement stick value to an unsigned offset centred on 128.
  function automatic logic [7:0] analog_to_offset(input logic [7:0] a);
    return {~a[7], a[6:0]};
  endfunction

endpackage

// File: rtl/paddle_emu_ch.sv
// One paddle channel: digital position, per-frame capture and per-line countdown.
// Define PADDLE_ACCEL_EN to double the digital step after a long button hold.
module paddle_emu_ch
  import paddle_emu_pkg::*;
#(
  parameter int unsigned POS_W = 8,
  parameter int unsigned SPD_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vs_rise_i,
  input  logic             hs_rise_i,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic [7:0]       analog_x_i,
  input  logic [7:0]       analog_y_i,
  input  logic [7:0]       paddle_i,
  input  src_e             src_sel_i,
  input  logic             invert_i,
  input  logic [SPD_W-1:0] step_i,
  output logic             pad_pin_o,
  output logic [POS_W-1:0] pos_o
);

  localparam logic [POS_W-1:0] PosReset = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W:0]   PosMax   = {1'b0, {POS_W{1'b1}}};

  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] cap_q, cap_d;
  logic [POS_W-1:0] inv_mask, pos_sub;
  logic [POS_W:0]   pos_ext, step_ext, pos_sum;
  logic [SPD_W:0]   step_eff;
  logic             mv_up, mv_dn;

  assign mv_up = btn_up_i & ~btn_down_i;
  assign mv_dn = btn_down_i & ~btn_up_i;

`ifdef PADDLE_ACCEL_EN
  logic [3:0] hold_q, hold_d;
  logic       dir_q, dir_d;  // 1 = moving down

  always_comb begin
    hold_d = hold_q;
    dir_d  = dir_q;
    if (vs_rise_i) begin
      if (mv_up | mv_dn) begin
        dir_d = mv_dn;
        if ((hold_q != 4'd0) && (dir_q != mv_dn)) begin
          hold_d = 4'd0;
        end else if (hold_q != 4'hF) begin
          hold_d = hold_q + 4'd1;
        end
      end else begin
        hold_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 4'd0;
      dir_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      dir_q  <= dir_d;
    end
  end

  assign step_eff = (hold_q >= 4'(ACCEL_THRESH)) ? {step_i, 1'b0} : {1'b0, step_i};
`else
  assign step_eff = {1'b0, step_i};
`endif

  assign inv_mask = {POS_W{invert_i}};
  assign pos_ext  = {1'b0, pos_q};
  assign step_ext = (POS_W+1)'(step_eff);
  assign pos_sum  = pos_ext + step_ext;
  assign pos_sub  = pos_q - step_ext[POS_W-1:0];

  always_comb begin
    pos_d = pos_q;
    cap_d = cap_q;
    if (vs_rise_i) begin
      case (src_sel_i)
        SRC_DIGITAL: begin
          // Capture the pre-move position; the movement shows up next frame.
          cap_d = pos_q ^ inv_mask;
          if (mv_up) begin
            pos_d = (pos_ext < step_ext) ? '0 : pos_sub;
          end else if (mv_dn) begin
            pos_d = (pos_sum > PosMax) ? '1 : pos_sum[POS_W-1:0];
          end
        end
        SRC_Y:   cap_d = (POS_W'(analog_to_offset(analog_y_i)) << (POS_W - 8)) ^ inv_mask;
        SRC_X:   cap_d = (POS_W'(analog_to_offset(analog_x_i)) << (POS_W - 8)) ^ inv_mask;
        SRC_PADDLE: cap_d = (POS_W'(paddle_i) << (POS_W - 8)) ^ inv_mask;
        default: cap_d = cap_q;
      endcase
    end else if (hs_rise_i && (cap_q != '0)) begin
      cap_d = cap_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= PosReset;
      cap_q <= '0;
    end else begin
      pos_q <= pos_d;
      cap_q <= cap_d;
    end
  end

  assign pad_pin_o = (cap_q == '0);
  assign pos_o     = pos_q;

endmodule

// File: rtl/paddle_emu_multi.sv
// Multi-channel RC-timer paddle emulator; owns HSYNC/VSYNC edge detection.
// Optional hold-to-accelerate is enabled by defining PADDLE_ACCEL_EN.
module paddle_emu_multi
  import paddle_emu_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned POS_W  = 8,
  parameter int unsigned SPD_W  = 5
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    hs,
  input  logic                    vs,
  input  logic [NUM_CH-1:0]       btn_up,
  input  logic [NUM_CH-1:0]       btn_down,
  input  logic [NUM_CH*8-1:0]     analog_x,
  input  logic [NUM_CH*8-1:0]     analog_y,
  input  logic [NUM_CH*8-1:0]     paddle,
  input  logic [NUM_CH*2-1:0]     src_sel,
  input  logic [NUM_CH-1:0]       invert,
  input  logic [SPD_W-1:0]        step_slow,
  input  logic [SPD_W-1:0]        step_fast,
  input  logic                    speed_fast,
  output logic [NUM_CH-1:0]       pad_pin,
  output logic [NUM_CH*POS_W-1:0] pos
);

  logic             hs_q, vs_q;
  logic             hs_rise, vs_rise;
  logic [SPD_W-1:0] step;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
    end
  end

  assign hs_rise = hs & ~hs_q;
  assign vs_rise = vs & ~vs_q;
  assign step    = speed_fast ? step_fast : step_slow;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    paddle_emu_ch #(
      .POS_W(POS_W),
      .SPD_W(SPD_W)
    ) u_ch (
      .clk_i      (clk_sys),
      .rst_i      (reset),
      .vs_rise_i  (vs_rise),
      .hs_rise_i  (hs_rise),
      .btn_up_i   (btn_up[g]),
      .btn_down_i (btn_down[g]),
      .analog_x_i (analog_x[g*8 +: 8]),
      .analog_y_i (analog_y[g*8 +: 8]),
      .paddle_i   (paddle[g*8 +: 8]),
      .src_sel_i  (src_e'(src_sel[g*2 +: 2])),
      .invert_i   (invert[g]),
      .step_i     (step),
      .pad_pin_o  (pad_pin[g]),
      .pos_o      (pos[g*POS_W +: POS_W])
    );
  end

endmodule

// File: tb/tb_paddle_emu_multi.sv
// Self-checking bench for paddle_emu_multi: vector table, corner sequences, random vs model.
module tb_paddle_emu_multi;

  logic        clk = 1'b0;
  logic        reset, hs, vs, speed_fast;
  logic [1:0]  btn_up, btn_down, invert, pad_pin;
  logic [15:0] analog_x, analog_y, paddle, pos;
  logic [3:0]  src_sel;
  logic [4:0]  step_slow, step_fast;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, in plain integers.
  int m_pos[2];
  int m_cap[2];
  int m_hold[2];
  bit m_dir[2];
  bit m_hs, m_vs;

  always #5 clk = ~clk;

  paddle_emu_multi #(
    .NUM_CH(2),
    .POS_W (8),
    .SPD_W (5)
  ) dut (
    .clk_sys   (clk),
    .reset     (reset),
    .hs        (hs),
    .vs        (vs),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .analog_x  (analog_x),
    .analog_y  (analog_y),
    .paddle    (paddle),
    .src_sel   (src_sel),
    .invert    (invert),
    .step_slow (step_slow),
    .step_fast (step_fast),
    .speed_fast(speed_fast),
    .pad_pin   (pad_pin),
    .pos       (pos)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit vsr, hsr, up, dn;
    int st, v;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_pos[c] = 128; m_cap[c] = 0; m_hold[c] = 0; m_dir[c] = 0;
      end
      m_hs = 0; m_vs = 0;
      return;
    end
    vsr = vs && !m_vs;
    hsr = hs && !m_hs;
    for (int c = 0; c < 2; c++) begin
      up = btn_up[c] && !btn_down[c];
      dn = btn_down[c] && !btn_up[c];
      if (vsr) begin
        st = speed_fast ? int'(step_fast) : int'(step_slow);
`ifdef PADDLE_ACCEL_EN
        if (m_hold[c] >= 8) st = st * 2;
        if (up || dn) begin
          if (m_hold[c] > 0 && m_dir[c] != dn) m_hold[c] = 0;
          else if (m_hold[c] < 15) m_hold[c] = m_hold[c] + 1;
          m_dir[c] = dn;
        end else begin
          m_hold[c] = 0;
        end
`endif
        case (src_sel[2*c +: 2])
          2'd0: begin
            m_cap[c] = invert[c] ? 255 - m_pos[c] : m_pos[c];
            if (up) m_pos[c] = (m_pos[c] - st < 0) ? 0 : m_pos[c] - st;
            else if (dn) m_pos[c] = (m_pos[c] + st > 255) ? 255 : m_pos[c] + st;
          end
          2'd1: begin
            v = $signed(analog_y[8*c +: 8]) + 128;
            m_cap[c] = invert[c] ? 255 - v : v;
          end
          2'd2: begin
            v = $signed(analog_x[8*c +: 8]) + 128;
            m_cap[c] = invert[c] ? 255 - v : v;
          end
          default: begin
            v = int'(paddle[8*c +: 8]);
            m_cap[c] = invert[c] ? 255 - v : v;
          end
        endcase
      end else if (hsr && m_cap[c] > 0) begin
        m_cap[c] = m_cap[c] - 1;
      end
    end
    m_hs = hs;
    m_vs = vs;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("pad_pin[%0d]", c), int'(pad_pin[c]), (m_cap[c] == 0) ? 1 : 0);
      check($sformatf("pos[%0d]", c), int'(pos[8*c +: 8]), m_pos[c]);
    end
  endtask

  task automatic frame();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  task automatic hs_pulse();
    hs = 1'b1; tick();
    hs = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick();
    reset = 1'b0;
  endtask

  task automatic count_lines(input int c, output int n);
    n = 0;
    while (pad_pin[c] == 1'b0 && n < 300) begin
      hs_pulse();
      n++;
    end
  endtask

  // Pulse one direction per frame, releasing between, so no hold builds up.
  task automatic move(input int c, input bit down, input int n);
    repeat (n) begin
      if (down) btn_down[c] = 1'b1; else btn_up[c] = 1'b1;
      frame();
      btn_up[c] = 1'b0; btn_down[c] = 1'b0;
      frame();
    end
  endtask

  typedef struct {
    logic [1:0] src;
    logic       inv;
    logic [7:0] val;
    int         exp_lines;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, prev, exp_step;
    vecs[0] = '{2'd2, 1'b0, 8'h80, 0};
    vecs[1] = '{2'd2, 1'b0, 8'h7F, 255};
    vecs[2] = '{2'd3, 1'b1, 8'd10, 245};
    vecs[3] = '{2'd1, 1'b0, 8'h00, 128};
    vecs[4] = '{2'd1, 1'b1, 8'h10, 111};
    vecs[5] = '{2'd3, 1'b0, 8'd20, 20};
    vecs[6] = '{2'd2, 1'b1, 8'hC0, 191};

    reset = 1'b1; hs = 1'b0; vs = 1'b0; speed_fast = 1'b0;
    btn_up = '0; btn_down = '0; invert = '0; src_sel = '0;
    analog_x = '0; analog_y = '0; paddle = '0;
    step_slow = 5'd5; step_fast = 5'd10;
    tick(); tick();
    reset = 1'b0;
    check("reset_pad_pin", int'(pad_pin), 3);
    check("reset_pos0", int'(pos[7:0]), 128);

    // Held up for three frames: capture lags movement by one frame.
    btn_up[0] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame();
      check("up_pos0", int'(pos[7:0]), 128 - 5 * (f + 1));
      count_lines(0, n);
      check("up_cap0_lines", n, 128 - 5 * f);
    end
    btn_up[0] = 1'b0;

    btn_up[1] = 1'b1; btn_down[1] = 1'b1;
    frame();
    check("both_pos1", int'(pos[15:8]), 128);
    btn_up[1] = 1'b0; btn_down[1] = 1'b0;

    // Clamp at both ends.
    do_reset();
    move(0, 1'b0, 25);
    check("clamp_pre_lo", int'(pos[7:0]), 3);
    move(0, 1'b0, 1);
    check("clamp_lo", int'(pos[7:0]), 0);
    step_slow = 5'd28;
    move(0, 1'b1, 9);
    check("clamp_pre_hi", int'(pos[7:0]), 252);
    step_slow = 5'd5;
    move(0, 1'b1, 1);
    check("clamp_hi", int'(pos[7:0]), 255);
    speed_fast = 1'b1; step_fast = 5'd9;
    move(0, 1'b0, 2);
    check("fast_step", int'(pos[7:0]), 237);
    speed_fast = 1'b0;

    // Vector table: analog/paddle capture measured in lines until the pin fires.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      src_sel[1:0] = vecs[i].src;
      invert[0]    = vecs[i].inv;
      analog_x[7:0] = vecs[i].val;
      analog_y[7:0] = vecs[i].val;
      paddle[7:0]   = vecs[i].val;
      frame();
      count_lines(0, n);
      check($sformatf("vec%0d_lines", i), n, vecs[i].exp_lines);
    end

    // Countdown edges around cap=245 and saturation at zero.
    src_sel[1:0] = 2'd3; invert[0] = 1'b1; paddle[7:0] = 8'd10;
    frame();
    repeat (244) hs_pulse();
    check("cap245_before", int'(pad_pin[0]), 0);
    hs_pulse();
    check("cap245_at", int'(pad_pin[0]), 1);
    repeat (3) hs_pulse();
    check("cap245_sat", int'(pad_pin[0]), 1);

    // vs and hs rising together: load wins.
    invert[0] = 1'b0; paddle[7:0] = 8'd20;
    hs = 1'b1; vs = 1'b1; tick();
    hs = 1'b0; vs = 1'b0; tick();
    count_lines(0, n);
    check("same_cycle_lines", n, 20);

    // Reset mid-countdown.
    paddle[7:0] = 8'd200;
    frame();
    repeat (5) hs_pulse();
    check("mid_pad_before", int'(pad_pin[0]), 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_reset_pad", int'(pad_pin[0]), 1);
    check("mid_reset_pos", int'(pos[7:0]), 128);

    // Continuous hold: acceleration kicks in only with the feature built in.
    src_sel = '0; step_slow = 5'd5; btn_down[0] = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      prev = int'(pos[7:0]);
      frame();
      exp_step = 5;
`ifdef PADDLE_ACCEL_EN
      if (f > 8) exp_step = 10;
`endif
      check($sformatf("hold_step_f%0d", f), int'(pos[7:0]) - prev, exp_step);
    end
    btn_down[0] = 1'b0;

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      hs         = 1'($urandom_range(0, 1));
      vs         = ($urandom_range(0, 15) == 0);
      btn_up     = 2'($urandom);
      btn_down   = 2'($urandom);
      invert     = 2'($urandom);
      src_sel    = 4'($urandom);
      analog_x   = 16'($urandom);
      analog_y   = 16'($urandom);
      paddle     = 16'($urandom);
      step_slow  = 5'($urandom);
      step_fast  = 5'($urandom);
      speed_fast = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paddle_emu_multi.md
Name: paddle_emu_multi

Overview:
- Emulates N RC-timer paddle inputs for AY-3-8500-class video chips.
- Per channel: a source (keyboard/digital joystick position, analog Y, analog X, or paddle) is sampled once per frame at VSYNC into a countdown. The countdown decrements once per HSYNC.
- The chip-facing pin asserts when the countdown reaches zero, so the paddle's line position tracks the input.
- Sits between the hps_io/joystick muxing and the video chip core; replaces the per-player paddle logic in the top level.

Parameters:
- NUM_CH, 2, number of paddle channels.
- POS_W, 8, position/countdown width in bits; must be >= 8.
- SPD_W, 5, width of the move-step inputs.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hs  in  1  horizontal sync, active high.
- vs  in  1  vertical sync, active high.
- btn_up  in  NUM_CH  per-channel digital up.
- btn_down  in  NUM_CH  per-channel digital down.
- analog_x  in  NUM_CH*8  per-channel signed analog X, two's complement.
- analog_y  in  NUM_CH*8  per-channel signed analog Y, two's complement.
- paddle  in  NUM_CH*8  per-channel unsigned paddle value.
- src_sel  in  NUM_CH*2  per-channel source select: 0 digital, 1 Y, 2 X, 3 paddle.
- invert  in  NUM_CH  per-channel value inversion.
- step_slow  in  SPD_W  digital move step when speed_fast=0.
- step_fast  in  SPD_W  digital move step when speed_fast=1.
- speed_fast  in  1  selects step_fast.
- pad_pin  out  NUM_CH  1 when channel countdown == 0, feeds the chip LP/RP input.
- pos  out  NUM_CH*POS_W  current digital position, for debug/OSD.

Behaviour:
- Reset, applied synchronously: pos = 2^(POS_W-1) (128 at default); cap = 0, so pad_pin = all 1; hs_d = vs_d = 0; hold counters = 0. Reset mid-frame aborts the countdown immediately.
- Edge detect: hs_d and vs_d are registered copies of hs and vs. vs_rise = vs & ~vs_d; hs_rise = hs & ~hs_d.
- On vs_rise, per channel, on the same clock:
  - src 0: cap <= pos ^ {POS_W{invert}}. pos moves by step (step_fast if speed_fast, else step_slow) in POS_W+1-bit arithmetic, clamped to [0, 2^POS_W-1].
  - up only: pos decreases. down only: pos increases. Both or neither: pos unchanged.
  - cap always takes the pre-move pos, so the position shown lags the movement by one frame.
  - src 1/2: v = {~a[7], a[6:0]} from analog_y or analog_x respectively. cap <= ({v, (POS_W-8)'b0}) ^ invert mask. pos is unchanged.
  - src 3: cap <= {paddle, zeros} ^ invert mask. pos is unchanged.
- Else on hs_rise: cap <= cap - 1 if cap != 0. Saturates at 0 and never wraps.
- vs_rise and hs_rise in the same cycle: the load wins and there is no decrement that cycle.
- pad_pin is combinational from the cap register (cap == 0). Visible the cycle after the edge cycle.
- src_sel and invert changes take effect at the next vs_rise only.
- Channels are fully independent; there is no shared state beyond edge detection.

Optional Feature:
- Macro PADDLE_ACCEL_EN.
- When defined, each channel has a 4-bit hold counter. It increments at each vs_rise while exactly one of up/down is held (saturates at 15) and clears when neither or both are held, or on direction change.
- The effective step is step << 1 when the hold count >= 8, computed in SPD_W+1 bits; clamping is unchanged.
- When not defined, there is no hold counter and the step is constant.

Decomposition:
- Package paddle_emu_pkg:
  - typedef enum logic [1:0] src_e {SRC_DIGITAL, SRC_Y, SRC_X, SRC_PADDLE};
  - localparam ACCEL_THRESH = 8.
  - function analog_to_offset(logic [7:0]) returning {~a[7], a[6:0]}.
- Sub-module paddle_emu_ch: one channel, with pos, cap and the optional hold counter. The top instantiates NUM_CH copies via generate and owns hs/vs edge detection.

Test Plan:
- Reset then hold btn_up[0] with step_slow=5, speed_fast=0 for 3 frames -> pos[0] = 128, 123, 118, 113 after each vs_rise; cap[0] loaded with 128, 123, 118.
- btn_up and btn_down both held on ch1, src 0 -> pos[1] stays 128. pos=3 with up held, step 5 -> pos clamps to 0. pos=252 with down held -> pos clamps to 255.
- src_sel[0]=2, analog_x=8'h80 (-128), invert=0 -> cap=0, pad_pin[0] high on the first line. analog_x=8'h7F -> cap=255, pad_pin[0] rises after the 255th hs_rise.
- src 3, paddle=10, invert=1 -> cap=245. After 244 hs_rise pad_pin=0; after the 245th pad_pin=1; further hs_rise keeps cap=0.
- vs_rise and hs_rise in the same cycle with src 3, paddle=20 -> cap=20, not 19. Assert reset mid-countdown -> next cycle cap=0, pad_pin=1, pos=128.
- With PADDLE_ACCEL_EN defined, step 5, down held for 10 frames -> increments of 5 for frames 1-8, then 10. With the macro undefined -> 5 throughout.
